// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: constants and state type shared by the instruction-memory
// loader, its byte packer and the instruction-memory model.
// Optional feature macro: IMEM_LOADER_CHECKSUM_EN (adds the CHECK state).
package imem_loader_pkg;

    localparam int DEF_ADDR_W     = 8;
    localparam int DEF_DEPTH      = 256;
    localparam int BYTES_PER_WORD = 4;
    localparam int BYTE_CNT_W     = 2;

`ifdef IMEM_LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ASSEMBLE = 3'd1,
        ST_WRITE    = 3'd2,
        ST_DONE     = 3'd3,
        ST_CHECK    = 3'd4
    } state_t;
`else
    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ASSEMBLE = 2'd1,
        ST_WRITE    = 2'd2,
        ST_DONE     = 2'd3
    } state_t;
`endif

    // True when the byte counter points at the final byte slot of a word.
    function automatic logic last_byte(input logic [BYTE_CNT_W-1:0] cnt);
        return cnt == BYTE_CNT_W'(BYTES_PER_WORD - 1);
    endfunction

endpackage

// File: rtl/imem_loader_if.sv
// imem_loader_if: byte-stream handshake plus instruction-memory write bus.
// The master side is the byte source / memory model, the slave side is the loader.
interface imem_loader_if
    import imem_loader_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W
);

    logic              byte_valid;
    logic [7:0]        byte_data;
    logic              byte_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;

    modport master (
        output byte_valid,
        output byte_data,
        input  byte_ready,
        input  imem_we,
        input  imem_addr,
        input  imem_wdata
    );

    modport slave (
        input  byte_valid,
        input  byte_data,
        output byte_ready,
        output imem_we,
        output imem_addr,
        output imem_wdata
    );

endinterface

// File: rtl/imem_word_packer.sv
// imem_word_packer: collects bytes big-endian into a 32-bit word.
// Only the three most recent bytes are stored; the fourth byte is merged
// combinationally so the completed word is available in the cycle it arrives.
module imem_word_packer
    import imem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        take,
    input  logic [7:0]  byte_in,
    output logic [31:0] packed_word,
    output logic        word_full
);

    logic [BYTE_CNT_W-1:0] cnt_r;
    logic [23:0]           word_r;

    assign packed_word = {word_r, byte_in};
    assign word_full   = take & last_byte(cnt_r);

    // Byte counter (mod 4) and shift register of the earlier bytes of the word.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r  <= {BYTE_CNT_W{1'b0}};
            word_r <= 24'h000000;
        end else if (clear) begin
            cnt_r  <= {BYTE_CNT_W{1'b0}};
            word_r <= 24'h000000;
        end else if (take) begin
            cnt_r  <= cnt_r + {{(BYTE_CNT_W-1){1'b0}}, 1'b1};
            word_r <= packed_word[23:0];
        end else begin
            cnt_r  <= cnt_r;
            word_r <= word_r;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// imem_loader: writes a byte-streamed program image into instruction memory,
// holding the CPU until the image is resident.
// Optional feature macro: IMEM_LOADER_CHECKSUM_EN (32-bit sum trailer check).
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DEPTH  = DEF_DEPTH
)
(
    input  logic              clk,
    input  logic              RegReset,
    input  logic              start,
    input  logic [ADDR_W:0]   num_words,
    imem_loader_if.slave      bus,
    output logic              cpu_hold,
    output logic              done,
    output logic              err
);

    localparam logic [ADDR_W:0] DEPTH_V = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] ONE_V   = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W:0] ZERO_V  = {(ADDR_W+1){1'b0}};

    state_t              state_r, next_state;
    logic [ADDR_W:0]     num_words_r, num_words_next;
    logic [ADDR_W:0]     word_cnt_r, word_cnt_next;
    logic                done_r, done_next;
    logic                err_r, err_next;
    logic                byte_ready_r, byte_ready_next;
    logic                cpu_hold_r, cpu_hold_next;
    logic                imem_we_r, imem_we_next;
    logic [ADDR_W-1:0]   imem_addr_r, imem_addr_next;
    logic [31:0]         imem_wdata_r, imem_wdata_next;
    logic                take;
    logic                pk_clear;
    logic                word_full;
    logic [31:0]         packed_word;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [31:0]         sum_r, sum_next;
`endif

    assign take           = bus.byte_valid & byte_ready_r;
    assign bus.byte_ready = byte_ready_r;
    assign bus.imem_we    = imem_we_r;
    assign bus.imem_addr  = imem_addr_r;
    assign bus.imem_wdata = imem_wdata_r;
    assign cpu_hold       = cpu_hold_r;
    assign done           = done_r;
    assign err            = err_r;

    imem_word_packer u_packer (
        .clk         (clk),
        .rst         (RegReset),
        .clear       (pk_clear),
        .take        (take),
        .byte_in     (bus.byte_data),
        .packed_word (packed_word),
        .word_full   (word_full)
    );

    // Next-state, word counter, sticky status flags and checksum update.
    always_comb begin
        next_state     = state_r;
        num_words_next = num_words_r;
        word_cnt_next  = word_cnt_r;
        done_next      = done_r;
        err_next       = err_r;
        pk_clear       = 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
        sum_next       = sum_r;
`endif
        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    num_words_next = num_words;
                    word_cnt_next  = ZERO_V;
                    pk_clear       = 1'b1;
                    done_next      = 1'b0;
                    err_next       = 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    sum_next       = 32'h0000_0000;
`endif
                    if (num_words > DEPTH_V) begin
                        // Image cannot fit: reject without touching memory.
                        next_state = ST_DONE;
                        done_next  = 1'b1;
                        err_next   = 1'b1;
                    end else if (num_words == ZERO_V) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                        // Empty image still carries a trailer (expected sum 0).
                        next_state = ST_CHECK;
`else
                        next_state = ST_DONE;
                        done_next  = 1'b1;
`endif
                    end else begin
                        next_state = ST_ASSEMBLE;
                    end
                end else begin
                    next_state = state_r;
                end
            end
            ST_ASSEMBLE: begin
                if (word_full) begin
                    next_state = ST_WRITE;
                end else begin
                    next_state = ST_ASSEMBLE;
                end
            end
            ST_WRITE: begin
                word_cnt_next = word_cnt_r + ONE_V;
`ifdef IMEM_LOADER_CHECKSUM_EN
                sum_next      = sum_r + imem_wdata_r;
`endif
                if (word_cnt_next == num_words_r) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                    next_state = ST_CHECK;
`else
                    next_state = ST_DONE;
                    done_next  = 1'b1;
`endif
                end else begin
                    next_state = ST_ASSEMBLE;
                end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            ST_CHECK: begin
                if (word_full) begin
                    next_state = ST_DONE;
                    done_next  = 1'b1;
                    err_next   = (packed_word != sum_r);
                end else begin
                    next_state = ST_CHECK;
                end
            end
`endif
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    // Output decode from the upcoming state so every output is a plain register.
    always_comb begin
        byte_ready_next = 1'b0;
        cpu_hold_next   = 1'b0;
        imem_we_next    = 1'b0;
        imem_addr_next  = {ADDR_W{1'b0}};
        imem_wdata_next = 32'h0000_0000;
        case (next_state)
            ST_ASSEMBLE: begin
                byte_ready_next = 1'b1;
                cpu_hold_next   = 1'b1;
            end
            ST_WRITE: begin
                cpu_hold_next   = 1'b1;
                imem_we_next    = 1'b1;
                imem_addr_next  = word_cnt_r[ADDR_W-1:0];
                imem_wdata_next = packed_word;
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            ST_CHECK: begin
                byte_ready_next = 1'b1;
                cpu_hold_next   = 1'b1;
            end
`endif
            default: begin
                byte_ready_next = 1'b0;
                cpu_hold_next   = 1'b0;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (RegReset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state;
        end
    end

    // Datapath and registered outputs; reset discards any load in progress.
    always_ff @(posedge clk) begin
        if (RegReset) begin
            num_words_r  <= ZERO_V;
            word_cnt_r   <= ZERO_V;
            done_r       <= 1'b0;
            err_r        <= 1'b0;
            byte_ready_r <= 1'b0;
            cpu_hold_r   <= 1'b0;
            imem_we_r    <= 1'b0;
            imem_addr_r  <= {ADDR_W{1'b0}};
            imem_wdata_r <= 32'h0000_0000;
`ifdef IMEM_LOADER_CHECKSUM_EN
            sum_r        <= 32'h0000_0000;
`endif
        end else begin
            num_words_r  <= num_words_next;
            word_cnt_r   <= word_cnt_next;
            done_r       <= done_next;
            err_r        <= err_next;
            byte_ready_r <= byte_ready_next;
            cpu_hold_r   <= cpu_hold_next;
            imem_we_r    <= imem_we_next;
            imem_addr_r  <= imem_addr_next;
            imem_wdata_r <= imem_wdata_next;
`ifdef IMEM_LOADER_CHECKSUM_EN
            sum_r        <= sum_next;
`endif
        end
    end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Writer side of the instruction memory that the fetch stage reads.
- Accepts a byte stream over a valid/ready handshake and packs it big-endian into 32-bit words.
- Writes each word into consecutive instruction-memory addresses starting at 0.
- Holds the pipeline (cpu_hold) while a load is in progress, so the processor begins fetching only after the whole program image is resident.

Parameters:
- ADDR_W, 8, instruction-memory word-address width.
- DEPTH, 256, number of words in instruction memory; must equal 2**ADDR_W.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- RegReset  in  1  synchronous, active-high reset.
- start  in  1  single-cycle request to begin a load; sampled only in IDLE or DONE.
- num_words  in  ADDR_W+1  number of words to load; sampled in the same cycle as start.
- byte_valid  in  1  source has a byte on byte_data.
- byte_data  in  8  stream byte.
- byte_ready  out  1  loader accepts a byte this cycle.
- imem_we  out  1  instruction-memory write strobe, one cycle per word.
- imem_addr  out  ADDR_W  word address of the current write.
- imem_wdata  out  32  assembled word.
- cpu_hold  out  1  asserted for the whole load; drives pipeline stall/hold.
- done  out  1  level-high after a load completes; cleared by start or reset.
- err  out  1  level-high when a load was rejected or failed; cleared by start or reset.

Behaviour:
- Reset: synchronous and active-high. When RegReset=1 at a clock edge:
  - state returns to IDLE;
  - every output is 0;
  - the byte counter, word counter and any partial word are cleared.
  - This applies mid-load as well; the partial word is discarded and no write is issued.
- States: IDLE, ASSEMBLE, WRITE, DONE (2-bit encoding).
- IDLE or DONE, start=1: latch num_words, clear done and err, then:
  - if num_words==0 → DONE with done=1 and no writes;
  - if num_words>DEPTH → DONE with err=1, done=1 and no writes;
  - otherwise → ASSEMBLE with cpu_hold=1 from the next cycle.
- start while in ASSEMBLE or WRITE is ignored.
- ASSEMBLE:
  - byte_ready=1; a byte transfers when byte_valid&byte_ready.
  - Byte k of the word (k=0..3) lands in bits [31-8k -: 8]; the byte counter increments mod 4.
  - The 4th transfer moves the state to WRITE on the next edge.
  - No transfer means state is held; there is no timeout.
- WRITE (exactly one cycle):
  - imem_we=1, imem_wdata=assembled word, imem_addr=word counter; byte_ready=0.
  - Next edge: word counter +1. If the new count equals the latched num_words → DONE, otherwise → ASSEMBLE.
- Latency:
  - 4th byte accepted at edge N → imem_we high in cycle N+1 → byte_ready high again in cycle N+2.
  - Throughput is at most 4 bytes per 5 cycles.
- Address wrap: imem_addr counts 0..num_words-1 and never wraps, because num_words≤DEPTH is enforced at start.
- DONE: cpu_hold=0, done=1, byte_ready=0. Bytes offered in DONE or IDLE are not accepted.
- cpu_hold:
  - 1 in ASSEMBLE and WRITE, 0 in IDLE and DONE;
  - registered, and deasserts in the same cycle done rises.

Optional Feature:
- Macro: IMEM_LOADER_CHECKSUM_EN.
- With the macro defined:
  - a 32-bit running sum (mod 2^32) of all written words is kept;
  - after the last word, state CHECK (3-bit state encoding) accepts 4 more big-endian bytes as the expected sum;
  - on the 4th byte → DONE with done=1, and err=1 if the sum mismatches;
  - memory contents are not rolled back.
  - cpu_hold stays 1 through CHECK.
  - With num_words==0 the trailer is still required and the expected sum is 0.
- Without the macro: no trailer, no CHECK state, and err is raised only by the num_words>DEPTH rejection.

Decomposition:
- Shared package:
  - state typedef (IDLE/ASSEMBLE/WRITE/DONE/CHECK);
  - BYTES_PER_WORD=4;
  - default ADDR_W/DEPTH constants shared with the instruction-memory model.
- One natural sub-module, imem_word_packer:
  - byte counter plus 32-bit shift/packing register;
  - outputs word_full;
  - instantiated once.
- FSM, address counter and checksum stay in imem_loader.

Test Plan:
- Basic load: start with num_words=2; stream 8 bytes 0x20,0x08,0x00,0x05,0x20,0x09,0x00,0x0C with byte_valid held high → imem_we pulses twice: addr 0 data 0x20080005, then addr 1 data 0x2009000C. Then done=1, cpu_hold=0, err=0.
- Backpressure and gaps: same image with byte_valid toggled every other cycle → identical writes. byte_ready is 0 in each WRITE cycle, and no byte is lost or duplicated.
- Bounds: num_words=0 → done=1 one cycle after start, no imem_we. num_words=257 with DEPTH=256 → done=1, err=1, no imem_we. num_words=256 → last write at addr 255, then DONE.
- Reset mid-operation: RegReset=1 after 2 bytes of word 1 → next cycle all outputs 0 and no write occurred. A new start with num_words=1 writes the fresh 4 bytes to addr 0.
- Start ignored and restart: a start pulse in ASSEMBLE changes nothing. A start in DONE clears done/err and reloads from addr 0.
- Checksum (IMEM_LOADER_CHECKSUM_EN):
  - words 0x00000001 and 0xFFFFFFFF with trailer 0x00000000 → err=0;
  - trailer 0x00000001 → err=1, done=1.
